// File: rtl/lcv_mul_acc_pipe_if.sv
// Operand and result handshake bundle for lcv_mul_acc_pipe.
// The sequencer side uses master; the MAC unit uses slave.
interface lcv_mul_acc_pipe_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 33
);
  logic                 inp_valid;
  logic                 inp_ready;
  logic [A_WIDTH-1:0]   inp_a;
  logic [B_WIDTH-1:0]   inp_b;
  logic [ACC_WIDTH-1:0] inp_c;
  logic [1:0]           inp_mode;
  logic                 inp_last;
  logic                 outp_valid;
  logic                 outp_ready;
  logic [OUT_WIDTH-1:0] outp_data;
  logic                 outp_ovf;

  modport master (
    output inp_valid, inp_a, inp_b, inp_c, inp_mode, inp_last, outp_ready,
    input  inp_ready, outp_valid, outp_data, outp_ovf
  );

  modport slave (
    input  inp_valid, inp_a, inp_b, inp_c, inp_mode, inp_last, outp_ready,
    output inp_ready, outp_valid, outp_data, outp_ovf
  );
endinterface

// File: rtl/lcv_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate: S1 operands, S2 product, S3 aligned
// product, then accumulator update with optional saturating narrow to the output.
module lcv_mul_acc_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 33,
  parameter bit SATURATE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  lcv_mul_acc_pipe_if.slave  io_bus
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_MAC  = 2'd1,
    MODE_MSUB = 2'd2,
    MODE_LOAD = 2'd3
  } mode_t;

  localparam logic signed [ACC_WIDTH-1:0] L_OUT_MAX = ACC_WIDTH'({(OUT_WIDTH-1){1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] L_OUT_MIN = ~L_OUT_MAX;

  logic w_stall;
  logic w_adv;

  logic                        r_s1_valid;
  logic signed [A_WIDTH-1:0]   r_s1_a;
  logic signed [B_WIDTH-1:0]   r_s1_b;
  logic signed [ACC_WIDTH-1:0] r_s1_c;
  mode_t                       r_s1_mode;
  logic                        r_s1_last;

  logic signed [P_WIDTH-1:0]   w_prod;
  logic                        r_s2_valid;
  logic signed [P_WIDTH-1:0]   r_s2_p;
  logic signed [ACC_WIDTH-1:0] r_s2_c;
  mode_t                       r_s2_mode;
  logic                        r_s2_last;

  logic                        r_s3_valid;
  logic signed [ACC_WIDTH-1:0] r_s3_p;
  logic signed [ACC_WIDTH-1:0] r_s3_c;
  mode_t                       r_s3_mode;
  logic                        r_s3_last;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_wrap;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_op_ovf;
  logic                        w_wrap_next;
  logic                        w_sat_hi;
  logic                        w_sat_lo;
  logic                        w_narrow_ovf;
  logic [OUT_WIDTH-1:0]        w_out;

  logic                        r_out_valid;
  logic [OUT_WIDTH-1:0]        r_out_data;
  logic                        r_out_ovf;

  // A held, unconsumed result freezes the whole pipe; ready never looks at inp_valid.
  assign w_stall          = r_out_valid && !io_bus.outp_ready;
  assign w_adv            = !w_stall;
  assign io_bus.inp_ready = w_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_mode  <= MODE_MUL;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= io_bus.inp_valid;
      r_s1_a     <= io_bus.inp_a;
      r_s1_b     <= io_bus.inp_b;
      r_s1_c     <= io_bus.inp_c;
      r_s1_mode  <= mode_t'(io_bus.inp_mode);
      r_s1_last  <= io_bus.inp_last;
    end
  end

  assign w_prod = P_WIDTH'(r_s1_a) * P_WIDTH'(r_s1_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
      r_s2_c     <= '0;
      r_s2_mode  <= MODE_MUL;
      r_s2_last  <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_p     <= w_prod;
      r_s2_c     <= r_s1_c;
      r_s2_mode  <= r_s1_mode;
      r_s2_last  <= r_s1_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_valid <= 1'b0;
      r_s3_p     <= '0;
      r_s3_c     <= '0;
      r_s3_mode  <= MODE_MUL;
      r_s3_last  <= 1'b0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      r_s3_p     <= ACC_WIDTH'(r_s2_p);
      r_s3_c     <= r_s2_c;
      r_s3_mode  <= r_s2_mode;
      r_s3_last  <= r_s2_last;
    end
  end

  // Signed overflow: operands of like sign (after negation for MSUB) giving a result of the other sign.
  always_comb begin
    w_sum       = '0;
    w_op_ovf    = 1'b0;
    w_wrap_next = r_wrap;
    case (r_s3_mode)
      MODE_MUL: begin
        w_sum       = r_s3_p + r_s3_c;
        w_op_ovf    = (r_s3_p[ACC_WIDTH-1] == r_s3_c[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_s3_p[ACC_WIDTH-1]);
        w_wrap_next = w_op_ovf;
      end
      MODE_MAC: begin
        w_sum       = r_acc + r_s3_p;
        w_op_ovf    = (r_acc[ACC_WIDTH-1] == r_s3_p[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        w_wrap_next = r_wrap | w_op_ovf;
      end
      MODE_MSUB: begin
        w_sum       = r_acc - r_s3_p;
        w_op_ovf    = (r_acc[ACC_WIDTH-1] != r_s3_p[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        w_wrap_next = r_wrap | w_op_ovf;
      end
      default: begin
        w_sum       = r_s3_c;
        w_wrap_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_sat_hi     = (w_sum > L_OUT_MAX);
    w_sat_lo     = (w_sum < L_OUT_MIN);
    w_narrow_ovf = w_sat_hi | w_sat_lo;
    w_out        = w_sum[OUT_WIDTH-1:0];
    if (SATURATE) begin
      if (w_sat_hi) begin
        w_out = L_OUT_MAX[OUT_WIDTH-1:0];
      end else if (w_sat_lo) begin
        w_out = L_OUT_MIN[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      if (r_s3_valid) begin
        r_acc  <= w_sum;
        r_wrap <= r_s3_last ? 1'b0 : w_wrap_next;
      end
      // Advancing implies any held result is being consumed, so a new last beat simply replaces it.
      if (r_s3_valid && r_s3_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out;
        r_out_ovf   <= w_wrap_next | w_narrow_ovf;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.outp_valid = r_out_valid;
  assign io_bus.outp_data  = r_out_data;
  assign io_bus.outp_ovf   = r_out_ovf;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Scoreboard bench for lcv_mul_acc_pipe: a saturating instance carries most
// scenarios, a truncating instance covers the narrowing-without-clamp case.
module tb_lcv_mul_acc_pipe;

  typedef struct {
    longint data;
    logic   ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcv_mul_acc_pipe_if #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(33)) bus ();
  lcv_mul_acc_pipe_if #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(33)) bus_t ();

  lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(33), .SATURATE(1'b1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(33), .SATURATE(1'b0)) u_dut_trunc (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_t)
  );

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam longint TWO32  = longint'(1) << 32;
  localparam longint TWO39  = longint'(1) << 39;

  // Drive one beat and hold it until accepted; queue its expected result if it is a last beat.
  task automatic send(input int mode, input int a, input int b, input longint c,
                      input int last, input bit push, input longint ed, input logic eo);
    bit   accepted;
    exp_t e;
    bus.inp_mode  = 2'(mode);
    bus.inp_a     = 16'(a);
    bus.inp_b     = 16'(b);
    bus.inp_c     = 40'(c);
    bus.inp_last  = 1'(last);
    bus.inp_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.inp_ready;
      @(posedge clk);
    end
    #1;
    bus.inp_valid = 1'b0;
    if (!accepted) begin
      n_total++;
      $display("FAIL send_accept: inp_ready stayed 0 for 200 cycles, required 1");
    end else if (push) begin
      e.data = ed;
      e.ovf  = eo;
      sb.push_back(e);
    end
  endtask

  // Wait for one output handshake; returns got=0 if none within budget cycles.
  task automatic wait_out(input int budget, output bit got, output longint d, output logic o);
    got = 1'b0;
    d   = 0;
    o   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.outp_valid && bus.outp_ready) begin
        got = 1'b1;
        d   = longint'($signed(bus.outp_data));
        o   = bus.outp_ovf;
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (bus.outp_valid !== 1'b0) $display("FAIL reset_valid: outp_valid=%b required 0", bus.outp_valid);
    else n_pass++;
    n_total++;
    if (bus.outp_data !== 33'd0) $display("FAIL reset_data: outp_data=%0d required 0", bus.outp_data);
    else n_pass++;
    n_total++;
    if (bus.outp_ovf !== 1'b0) $display("FAIL reset_ovf: outp_ovf=%b required 0", bus.outp_ovf);
    else n_pass++;
    n_total++;
    if (bus.inp_ready !== 1'b1) $display("FAIL reset_ready: inp_ready=%b required 1", bus.inp_ready);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit got; longint d; logic o; exp_t e;
    send(0, 3, -4, 10, 1, 1'b1, -2, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.outp_valid !== 1'b0) $display("FAIL single_latency_early: outp_valid=%b two edges after accept, required 0", bus.outp_valid);
    else n_pass++;
    wait_out(1, got, d, o);
    n_total++;
    if (!got || sb.size() == 0) $display("FAIL single_result: no result on third edge after accept, required -2");
    else begin
      e = sb.pop_front();
      if (d !== e.data || o !== e.ovf) $display("FAIL single_result: data=%0d ovf=%b required data=%0d ovf=%b", d, o, e.data, e.ovf);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (bus.outp_valid !== 1'b0) $display("FAIL single_pulse: outp_valid=%b after consume, required 0", bus.outp_valid);
    else n_pass++;
    $display("single MUL 3*-4+10 -> %0d ovf=%b", d, o);
  endtask

  task automatic test_chain();
    bit got; longint d; logic o; exp_t e; int extra;
    send(0, 1000, 1000, 0, 0, 1'b0, 0, 1'b0);
    send(1, 2000, 2000, 0, 0, 1'b0, 0, 1'b0);
    send(2, 500, 2, 0, 1, 1'b1, 4999000, 1'b0);
    wait_out(10, got, d, o);
    n_total++;
    if (!got || sb.size() == 0) $display("FAIL chain_result: no result, required 4999000");
    else begin
      e = sb.pop_front();
      if (d !== e.data || o !== e.ovf) $display("FAIL chain_result: data=%0d ovf=%b required data=%0d ovf=%b", d, o, e.data, e.ovf);
      else n_pass++;
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.outp_valid) extra++;
    end
    n_total++;
    if (extra != 0) $display("FAIL chain_single_output: %0d extra output cycles, required 0", extra);
    else n_pass++;
    $display("chain MUL/MAC/MSUB -> %0d ovf=%b", d, o);
  endtask

  task automatic test_saturate();
    bit got; longint d; logic o; exp_t e;
    send(0, -32768, -32768, TWO32, 1, 1'b1, TWO32 - 1, 1'b1);
    wait_out(10, got, d, o);
    n_total++;
    if (!got || sb.size() == 0) $display("FAIL sat_clamp: no result, required 4294967295");
    else begin
      e = sb.pop_front();
      if (d !== e.data || o !== e.ovf) $display("FAIL sat_clamp: data=%0d ovf=%b required data=%0d ovf=%b", d, o, e.data, e.ovf);
      else n_pass++;
    end
    $display("saturate MUL -32768*-32768+2^32 -> %0d ovf=%b", d, o);
  endtask

  task automatic test_truncate();
    bit got; longint d; logic o;
    @(posedge clk);
    #1;
    bus_t.inp_mode  = 2'd0;
    bus_t.inp_a     = 16'h8000;
    bus_t.inp_b     = 16'h8000;
    bus_t.inp_c     = 40'(TWO32);
    bus_t.inp_last  = 1'b1;
    bus_t.inp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_t.inp_valid = 1'b0;
    got = 1'b0; d = 0; o = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus_t.outp_valid) begin
        got = 1'b1;
        d   = longint'($signed(bus_t.outp_data));
        o   = bus_t.outp_ovf;
      end
    end
    n_total++;
    if (!got) $display("FAIL trunc_wrap: no result, required -3221225472");
    else if (d !== -64'sd3221225472 || o !== 1'b1) $display("FAIL trunc_wrap: data=%0d ovf=%b required data=-3221225472 ovf=1", d, o);
    else n_pass++;
    @(posedge clk);
    #1;
    $display("truncate MUL -32768*-32768+2^32 -> %0d ovf=%b", d, o);
  endtask

  task automatic test_acc_wrap();
    bit got; longint d; logic o; exp_t e;
    send(3, 0, 0, TWO39 - 1, 0, 1'b0, 0, 1'b0);
    send(1, 1, 1, 0, 1, 1'b1, -TWO32, 1'b1);
    send(0, 2, 2, 0, 1, 1'b1, 4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_out(10, got, d, o);
      n_total++;
      if (!got || sb.size() == 0) $display("FAIL wrap_result%0d: no result", k);
      else begin
        e = sb.pop_front();
        if (d !== e.data || o !== e.ovf) $display("FAIL wrap_result%0d: data=%0d ovf=%b required data=%0d ovf=%b", k, d, o, e.data, e.ovf);
        else n_pass++;
      end
      $display("wrap beat %0d -> %0d ovf=%b", k, d, o);
    end
  endtask

  task automatic test_bubbles();
    bit got; longint d; logic o; exp_t e;
    send(3, 7, 9, 100, 0, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    send(1, 2, 3, 0, 1, 1'b1, 106, 1'b0);
    wait_out(10, got, d, o);
    n_total++;
    if (!got || sb.size() == 0) $display("FAIL bubble_hold: no result, required 106");
    else begin
      e = sb.pop_front();
      if (d !== e.data || o !== e.ovf) $display("FAIL bubble_hold: data=%0d ovf=%b required data=%0d ovf=%b", d, o, e.data, e.ovf);
      else n_pass++;
    end
    $display("bubbles LOAD 100, gaps, MAC 2*3 -> %0d ovf=%b", d, o);
  endtask

  task automatic test_back_to_back();
    bit got; longint d; logic o; exp_t e; bit seen; bit stable;
    logic [32:0] hold_d; logic hold_o; int extra;
    bus.outp_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++) send(0, k, 1, 0, 1, 1'b1, longint'(k), 1'b0);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = bus.outp_valid;
        end
        n_total++;
        if (!seen || bus.inp_ready !== 1'b0) $display("FAIL bp_ready_fall: valid=%b inp_ready=%b in first stalled cycle, required 1/0", seen, bus.inp_ready);
        else n_pass++;
        hold_d = bus.outp_data;
        hold_o = bus.outp_ovf;
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (bus.outp_data !== hold_d || bus.outp_ovf !== hold_o || bus.outp_valid !== 1'b1 || bus.inp_ready !== 1'b0) stable = 1'b0;
        end
        n_total++;
        if (!stable) $display("FAIL bp_stable: held output changed during stall, required data=%0d held", hold_d);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.outp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
          wait_out(30, got, d, o);
          n_total++;
          if (!got || sb.size() == 0) $display("FAIL bp_out%0d: no result, required %0d", k, k);
          else begin
            e = sb.pop_front();
            if (d !== e.data || o !== e.ovf) $display("FAIL bp_out%0d: data=%0d ovf=%b required data=%0d ovf=%b", k, d, o, e.data, e.ovf);
            else n_pass++;
          end
          $display("backpressure out %0d -> %0d ovf=%b", k, d, o);
        end
      end
    join
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.outp_valid) extra++;
    end
    n_total++;
    if (extra != 0 || sb.size() != 0) $display("FAIL bp_no_dup: extra=%0d pending=%0d, required 0/0", extra, sb.size());
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    bit got; longint d; logic o; exp_t e; int extra;
    bus.outp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(0, k, 1, 0, 1, 1'b0, 0, 1'b0);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.outp_valid !== 1'b0 || bus.inp_ready !== 1'b1) $display("FAIL rst_mid_now: valid=%b ready=%b, required 0/1", bus.outp_valid, bus.inp_ready);
    else n_pass++;
    n_total++;
    if (bus.outp_data !== 33'd0 || bus.outp_ovf !== 1'b0) $display("FAIL rst_mid_data: data=%0d ovf=%b, required 0/0", bus.outp_data, bus.outp_ovf);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.outp_valid !== 1'b0 || bus.inp_ready !== 1'b1) $display("FAIL rst_mid_held: valid=%b ready=%b, required 0/1", bus.outp_valid, bus.inp_ready);
    else n_pass++;
    rst = 1'b1;
    bus.outp_ready = 1'b1;
    sb.delete();
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.outp_valid) extra++;
    end
    n_total++;
    if (extra != 0) $display("FAIL rst_mid_discard: %0d outputs after reset, required 0", extra);
    else n_pass++;
    @(posedge clk);
    #1;
    send(1, 2, 3, 0, 1, 1'b1, 6, 1'b0);
    wait_out(10, got, d, o);
    n_total++;
    if (!got || sb.size() == 0) $display("FAIL rst_mid_mac: no result, required 6");
    else begin
      e = sb.pop_front();
      if (d !== e.data || o !== e.ovf) $display("FAIL rst_mid_mac: data=%0d ovf=%b required data=%0d ovf=%b", d, o, e.data, e.ovf);
      else n_pass++;
    end
    $display("reset mid-stream then MAC 2*3 -> %0d ovf=%b", d, o);
  endtask

  initial begin
    bus.inp_valid    = 1'b0;
    bus.inp_a        = '0;
    bus.inp_b        = '0;
    bus.inp_c        = '0;
    bus.inp_mode     = '0;
    bus.inp_last     = 1'b0;
    bus.outp_ready   = 1'b1;
    bus_t.inp_valid  = 1'b0;
    bus_t.inp_a      = '0;
    bus_t.inp_b      = '0;
    bus_t.inp_c      = '0;
    bus_t.inp_mode   = '0;
    bus_t.inp_last   = 1'b0;
    bus_t.outp_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_chain();
    test_saturate();
    test_truncate();
    test_acc_wrap();
    test_bubbles();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
